// File: rtl/dram_ctl_pkg.sv
// Shared types, default timing and helpers for the fast-page-mode DRAM controller.
package dram_ctl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_ACK,
        S_PAGE,
        S_PRECHG,
        S_REF_CBR,
        S_REF_RAS
    } dram_state_t;

    localparam int DEF_AOUT         = 4;
    localparam int DEF_T_RCD        = 2;
    localparam int DEF_T_CAS_RD     = 2;
    localparam int DEF_T_CAS_WR     = 1;
    localparam int DEF_T_CBR        = 1;
    localparam int DEF_T_RFC        = 1;
    localparam int DEF_T_RP         = 1;
    localparam int DEF_REF_INTERVAL = 25;
    localparam int DEF_PAGE_MODE    = 1;
    localparam int DEF_PAGE_TIMEOUT = 8;

    // Width of the shared phase counter: must hold the largest timing value.
    function automatic int cnt_width(input int t_rcd, input int t_rd, input int t_wr,
                                     input int t_cbr, input int t_rfc, input int t_rp,
                                     input int t_page);
        int m;
        m = t_rcd;
        if (t_rd > m)   m = t_rd;
        if (t_wr > m)   m = t_wr;
        if (t_cbr > m)  m = t_cbr;
        if (t_rfc > m)  m = t_rfc;
        if (t_rp > m)   m = t_rp;
        if (t_page > m) m = t_page;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer: raises a pending request every REF_INTERVAL cycles
// and flags an overrun when the previous request has not yet been taken.
module dram_refresh_timer #(
    parameter int REF_INTERVAL = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic ref_taken,
    output logic refresh_pend,
    output logic ref_overrun
);
    localparam int TW = $clog2(REF_INTERVAL);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic          expire;

    always_comb begin
        expire = (tmr_q == '0);
        tmr_d  = expire ? TW'(REF_INTERVAL - 1) : tmr_q - 1'b1;
        pend_d = pend_q;
        // A new expiry outranks the clear, so a request arriving as one is taken is kept.
        if (ref_taken) pend_d = 1'b0;
        if (expire)    pend_d = 1'b1;
        ovr_d  = expire && pend_q && !ref_taken;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q  <= TW'(REF_INTERVAL - 1);
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign refresh_pend = pend_q;
    assign ref_overrun  = ovr_q;

endmodule

// File: rtl/dram_control_pm.sv
// Asynchronous-DRAM controller with fast-page mode and CAS-before-RAS refresh;
// strobes and ack are registered from the current state, one cycle behind it.
module dram_control_pm
    import dram_ctl_pkg::*;
#(
    parameter int AOUT         = DEF_AOUT,
    parameter int AIN          = 2 * AOUT,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_CAS_RD     = DEF_T_CAS_RD,
    parameter int T_CAS_WR     = DEF_T_CAS_WR,
    parameter int T_CBR        = DEF_T_CBR,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int T_RP         = DEF_T_RP,
    parameter int REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int PAGE_MODE    = DEF_PAGE_MODE,
    parameter int PAGE_TIMEOUT = DEF_PAGE_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            as_n,
    input  logic [AIN-1:0]  addr_in,
    input  logic            rw,
    output logic [AOUT-1:0] addr_out,
    output logic            ras_n,
    output logic            cas_n,
    output logic            we_n,
    output logic            ack,
    output logic            ref_overrun
);
    localparam int CW = cnt_width(T_RCD, T_CAS_RD, T_CAS_WR, T_CBR, T_RFC, T_RP, PAGE_TIMEOUT);

    dram_state_t     state_q;
    logic [CW-1:0]   cnt_q;
    logic [AOUT-1:0] row_q, col_q, addr_q;
    logic            rw_q, ras_n_q, cas_n_q, we_n_q, ack_q;
    logic            refresh_pend, ref_taken, req;

    assign ref_taken = (state_q == S_IDLE) && refresh_pend;
    // The processor still holds as_n during the ack cycle; that is not a new request.
    assign req       = !as_n && !ack_q;

    dram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref (
        .clk          (clk),
        .reset        (reset),
        .ref_taken    (ref_taken),
        .refresh_pend (refresh_pend),
        .ref_overrun  (ref_overrun)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            ras_n_q <= !(state_q inside {S_ROW, S_COL, S_ACK, S_PAGE, S_REF_RAS});
            cas_n_q <= !(state_q inside {S_COL, S_ACK, S_REF_CBR, S_REF_RAS});
            we_n_q  <= !((state_q inside {S_COL, S_ACK}) && !rw_q);
            ack_q   <= (state_q == S_ACK);
            if (state_q == S_ROW)
                addr_q <= row_q;
            else if (state_q == S_COL)
                addr_q <= col_q;

            // Timed states load cnt_q with duration-1 on entry and leave when it reaches 0.
            case (state_q)
                S_IDLE: begin
                    if (refresh_pend) begin
                        state_q <= S_REF_CBR;
                        cnt_q   <= CW'(T_CBR - 1);
                    end else if (req) begin
                        row_q   <= addr_in[AIN-1:AOUT];
                        col_q   <= addr_in[AOUT-1:0];
                        rw_q    <= rw;
                        state_q <= S_ROW;
                        cnt_q   <= CW'(T_RCD - 1);
                    end
                end
                S_ROW: begin
                    if (cnt_q == '0) begin
                        state_q <= S_COL;
                        cnt_q   <= rw_q ? CW'(T_CAS_RD - 1) : CW'(T_CAS_WR - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_COL: begin
                    if (cnt_q == '0) state_q <= S_ACK;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                S_ACK: begin
                    if (PAGE_MODE != 0 && !refresh_pend) begin
                        state_q <= S_PAGE;
                        cnt_q   <= CW'(PAGE_TIMEOUT - 1);
                    end else begin
                        state_q <= S_PRECHG;
                        cnt_q   <= CW'(T_RP - 1);
                    end
                end
                S_PAGE: begin
                    if (refresh_pend || (req && addr_in[AIN-1:AOUT] != row_q) || (!req && cnt_q == '0)) begin
                        state_q <= S_PRECHG;
                        cnt_q   <= CW'(T_RP - 1);
                    end else if (req) begin
                        col_q   <= addr_in[AOUT-1:0];
                        rw_q    <= rw;
                        state_q <= S_COL;
                        cnt_q   <= rw ? CW'(T_CAS_RD - 1) : CW'(T_CAS_WR - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_PRECHG: begin
                    if (cnt_q == '0) state_q <= S_IDLE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                S_REF_CBR: begin
                    if (cnt_q == '0) begin
                        state_q <= S_REF_RAS;
                        cnt_q   <= CW'(T_RFC - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_REF_RAS: begin
                    if (cnt_q == '0) begin
                        state_q <= S_PRECHG;
                        cnt_q   <= CW'(T_RP - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign addr_out = addr_q;
    assign ras_n    = ras_n_q;
    assign cas_n    = cas_n_q;
    assign we_n     = we_n_q;
    assign ack      = ack_q;

endmodule

// File: tb/tb_dram_control_pm.sv
// Directed bench for dram_control_pm: default instance plus a REF_INTERVAL=8 instance for overrun.
module tb_dram_control_pm;
    logic       clk = 1'b0;
    logic       reset = 1'b1, as_n = 1'b1, rw = 1'b1;
    logic [7:0] addr_in = 8'h00;
    logic [3:0] addr_out;
    logic       ras_n, cas_n, we_n, ack, ref_overrun;

    logic       reset2 = 1'b1, as2_n = 1'b1, rw2 = 1'b1;
    logic [7:0] addr2_in = 8'h00;
    logic [3:0] addr2_out;
    logic       ras2_n, cas2_n, we2_n, ack2, ovr2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dram_control_pm dut (
        .clk(clk), .reset(reset), .as_n(as_n), .addr_in(addr_in), .rw(rw),
        .addr_out(addr_out), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ack(ack), .ref_overrun(ref_overrun)
    );

    dram_control_pm #(.REF_INTERVAL(8), .T_CAS_RD(20), .T_RFC(3)) dut2 (
        .clk(clk), .reset(reset2), .as_n(as2_n), .addr_in(addr2_in), .rw(rw2),
        .addr_out(addr2_out), .ras_n(ras2_n), .cas_n(cas2_n), .we_n(we2_n),
        .ack(ack2), .ref_overrun(ovr2)
    );

    // Observed bus packed as {ras_n, cas_n, we_n, ack, addr_out}.
    logic [7:0] obs;
    assign obs = {ras_n, cas_n, we_n, ack, addr_out};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        as_n  = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        as_n = 1'b0; addr_in = 8'h00; rw = 1'b1; reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (obs !== 8'hE0 || ref_overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold step %0d: got %h/%b expected e0/0", k, obs, ref_overrun);
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs !== 8'hE0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %h expected e0", obs);
        end
        tick();
        n_checks++;
        if (obs !== 8'h60) begin
            n_fail++;
            $display("FAIL reset_release_row: got %h expected 60", obs);
        end
    endtask

    task automatic test_read();
        logic [7:0] exp_v [1:6];
        exp_v = '{8'hE0, 8'h6A, 8'h6A, 8'h25, 8'h25, 8'h35};
        do_reset();
        as_n = 1'b0; addr_in = 8'hA5; rw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_v[k]) begin
                n_fail++;
                $display("FAIL read step %0d: got %h expected %h", k, obs, exp_v[k]);
            end
        end
        as_n = 1'b1;
    endtask

    task automatic test_page_hit();
        logic [7:0] exp_v [1:9];
        exp_v = '{8'hE0, 8'h63, 8'h63, 8'h01, 8'h11, 8'h61, 8'h61, 8'h0C, 8'h1C};
        do_reset();
        as_n = 1'b0; addr_in = 8'h31; rw = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_v[k]) begin
                n_fail++;
                $display("FAIL page_hit step %0d: got %h expected %h", k, obs, exp_v[k]);
            end
            if (k == 5) as_n = 1'b1;
            if (k == 6) begin as_n = 1'b0; addr_in = 8'h3C; rw = 1'b0; end
        end
        as_n = 1'b1;
    endtask

    task automatic test_page_miss();
        logic [7:0] exp_v [1:14];
        exp_v = '{8'hE0, 8'h63, 8'h63, 8'h01, 8'h11, 8'h61, 8'h61,
                  8'hE1, 8'hE1, 8'h67, 8'h67, 8'h21, 8'h21, 8'h31};
        do_reset();
        as_n = 1'b0; addr_in = 8'h31; rw = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            n_checks++;
            if (obs !== exp_v[k]) begin
                n_fail++;
                $display("FAIL page_miss step %0d: got %h expected %h", k, obs, exp_v[k]);
            end
            if (k == 5) as_n = 1'b1;
            if (k == 6) begin as_n = 1'b0; addr_in = 8'h71; rw = 1'b1; end
        end
        as_n = 1'b1;
    endtask

    task automatic test_page_timeout();
        logic [7:0] e;
        do_reset();
        as_n = 1'b0; addr_in = 8'h31; rw = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            case (k)
                1:       e = 8'hE0;
                2, 3:    e = 8'h63;
                4:       e = 8'h01;
                5:       e = 8'h11;
                14:      e = 8'hE1;
                default: e = 8'h61;
            endcase
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL page_timeout step %0d: got %h expected %h", k, obs, e);
            end
            if (k == 5) as_n = 1'b1;
        end
    endtask

    task automatic test_refresh_priority();
        logic [7:0] exp_v [1:15];
        int acks;
        exp_v = '{8'hE0, 8'hA0, 8'h20, 8'hE0, 8'hE0, 8'h65, 8'h65, 8'h0A, 8'h1A,
                  8'h6A, 8'h6A, 8'h6A, 8'h6A, 8'h6A, 8'h6A};
        acks = 0;
        do_reset();
        repeat (25) tick();
        as_n = 1'b0; addr_in = 8'h5A; rw = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (ack === 1'b1) acks++;
            n_checks++;
            if (obs !== exp_v[j]) begin
                n_fail++;
                $display("FAIL refresh_prio step %0d: got %h expected %h", j, obs, exp_v[j]);
            end
            if (j == 9) as_n = 1'b1;
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL refresh_prio_ack_count: got %0d expected 1", acks);
        end
    endtask

    task automatic test_overrun();
        logic e_ovr;
        int   pulses;
        pulses = 0;
        reset2 = 1'b1; as2_n = 1'b1;
        repeat (3) tick();
        reset2 = 1'b0;
        as2_n = 1'b0; addr2_in = 8'h12; rw2 = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            tick();
            e_ovr = (k == 16) || (k == 24);
            if (ovr2 === 1'b1) pulses++;
            n_checks++;
            if (ovr2 !== e_ovr) begin
                n_fail++;
                $display("FAIL overrun step %0d: got %b expected %b", k, ovr2, e_ovr);
            end
            if (k == 24) begin
                n_checks++;
                if (ack2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overrun_ack: got %b expected 1", ack2);
                end
                as2_n = 1'b1;
            end
            if (k == 28 || k == 29) begin
                n_checks++;
                if ({ras2_n, cas2_n, we2_n} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL ref_ras step %0d: got %b expected 001", k, {ras2_n, cas2_n, we2_n});
                end
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++;
            $display("FAIL overrun_pulse_count: got %0d expected 2", pulses);
        end
        reset2 = 1'b1;
        tick();
        n_checks++;
        if ({ras2_n, cas2_n, we2_n, ack2, addr2_out, ovr2} !== 9'b1110_0000_0) begin
            n_fail++;
            $display("FAIL reset_mid_refresh: got %b expected 111000000",
                     {ras2_n, cas2_n, we2_n, ack2, addr2_out, ovr2});
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_page_hit();
        test_page_miss();
        test_page_timeout();
        test_refresh_priority();
        test_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
